// File: rtl/y_mem_pkg.sv
// rtl/y_mem_pkg.sv - shared widths and loader FSM states for the Y SRAM write path
// Contents:
//   Y_ADDR_W       SRAM row address width (2048 rows)
//   Y_ROW_W        SRAM row width, matches Y_WriteBus
//   Y_WORD_W       producer word width
//   WORDS_PER_ROW  producer words packed into one row
//   state_e        y_row_loader FSM states (CHECK states only reached with READBACK_CHECK_EN)
package y_mem_pkg;

  localparam int Y_ADDR_W      = 11;
  localparam int Y_ROW_W       = 256;
  localparam int Y_WORD_W      = 32;
  localparam int WORDS_PER_ROW = Y_ROW_W / Y_WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FILL       = 3'd1,
    ST_WRITE      = 3'd2,
    ST_CHECK_ADDR = 3'd3,
    ST_CHECK_CMP  = 3'd4,
    ST_FINISH     = 3'd5
  } state_e;

endpackage

// File: rtl/y_row_packer.sv
// rtl/y_row_packer.sv - packs producer words into one SRAM row, word 0 in the LSBs
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   clear           restart packing at word 0 (new load)
//   push            a word is accepted this cycle
//   word            accepted word
//   row_next        complete row as it stands after this cycle's push
//   full            this cycle's push delivers the last word of the row
module y_row_packer #(
  parameter int WORD_W = 32,
  parameter int ROW_W  = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [WORD_W-1:0] word,
  output logic [ROW_W-1:0]  row_next,
  output logic              full
);

  localparam int WORDS = ROW_W / WORD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int HELD_W = ROW_W - WORD_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  // Words enter at the top and shift down, so after WORDS pushes word 0 sits in
  // the LSBs. Only the upper HELD_W bits need storage: the newest word arrives
  // directly from the input on the completing cycle.
  logic [HELD_W-1:0] held_q, held_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign row_next = {word, held_q};
  assign full     = (cnt_q == LAST);

  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (push) begin
      held_d = row_next[ROW_W-1:WORD_W];
      cnt_d  = full ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_q <= '0;
      cnt_q  <= '0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/y_row_loader.sv
// rtl/y_row_loader.sv - streams 32-bit words into num_rows consecutive Y SRAM rows
// Build option: READBACK_CHECK_EN adds a read-back compare after every row write.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   start                   launch pulse, honoured only when not busy
//   base_addr, num_rows     first row and row count (0..2048), sampled on start
//   in_valid/in_data        producer word stream, accepted with in_ready
//   in_ready                block takes a word this cycle
//   Y_WE/Y_WriteAddress/Y_WriteBus  SRAM write port, one Y_WE cycle per row
//   Y_ReadAddress1/Y_ReadBus1       SRAM read-back port (driven 0 / ignored without check)
//   busy, done, error       load in progress, end-of-load pulse, sticky read-back mismatch
module y_row_loader
  import y_mem_pkg::*;
#(
  parameter int WORD_W = Y_WORD_W,
  parameter int ROW_W  = Y_ROW_W,
  parameter int ADDR_W = Y_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_rows,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              Y_WE,
  output logic [ADDR_W-1:0] Y_WriteAddress,
  output logic [ROW_W-1:0]  Y_WriteBus,
  output logic [ADDR_W-1:0] Y_ReadAddress1,
  input  logic [ROW_W-1:0]  Y_ReadBus1,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ROWS_ONE = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rows_left_q, rows_left_d;
  logic                in_ready_q, in_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ROW_W-1:0]    wr_bus_q, wr_bus_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic                start_ok;
  logic [ROW_W-1:0]    row_next;
  logic                row_full;

  // in_ready_q is only ever set in FILL, so accept implies FILL.
  assign accept   = in_valid & in_ready_q;
  assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_FINISH));

  y_row_packer #(
    .WORD_W (WORD_W),
    .ROW_W  (ROW_W)
  ) u_packer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (start_ok),
    .push     (accept),
    .word     (in_data),
    .row_next (row_next),
    .full     (row_full)
  );

`ifdef READBACK_CHECK_EN
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
`else
  logic unused_read_bus;
  assign unused_read_bus = ^Y_ReadBus1;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rows_left_d = rows_left_q;
    in_ready_d  = in_ready_q;
    we_d        = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_bus_d    = wr_bus_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
`ifdef READBACK_CHECK_EN
    rd_addr_d   = rd_addr_q;
`endif

    case (state_q)
      // FINISH is the done-pulse cycle; it takes a new start just like IDLE.
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        if (start) begin
          error_d = 1'b0;
          if (num_rows == '0) begin
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            addr_d      = base_addr;
            rows_left_d = num_rows;
            busy_d      = 1'b1;
            in_ready_d  = 1'b1;
            state_d     = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (accept && row_full) begin
          in_ready_d = 1'b0;
          we_d       = 1'b1;
          wr_addr_d  = addr_q;
          wr_bus_d   = row_next;
          state_d    = ST_WRITE;
        end
      end

      // Y_WE is high during this state; advance to the next row.
      ST_WRITE: begin
        addr_d      = addr_q + ADDR_ONE;
        rows_left_d = rows_left_q - ROWS_ONE;
`ifdef READBACK_CHECK_EN
        rd_addr_d   = addr_q;
        state_d     = ST_CHECK_ADDR;
`else
        if (rows_left_q == ROWS_ONE) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FINISH;
        end else begin
          in_ready_d = 1'b1;
          state_d    = ST_FILL;
        end
`endif
      end

`ifdef READBACK_CHECK_EN
      // Read address is on the bus this cycle; data returns next cycle.
      ST_CHECK_ADDR: begin
        state_d = ST_CHECK_CMP;
      end

      ST_CHECK_CMP: begin
        if (Y_ReadBus1 != wr_bus_q) begin
          error_d = 1'b1;
        end
        if (rows_left_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FINISH;
        end else begin
          in_ready_d = 1'b1;
          state_d    = ST_FILL;
        end
      end
`endif

      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        in_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rows_left_q <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_bus_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rows_left_q <= rows_left_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      wr_addr_q   <= wr_addr_d;
      wr_bus_q    <= wr_bus_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

`ifdef READBACK_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
    end
  end
  assign Y_ReadAddress1 = rd_addr_q;
`else
  assign Y_ReadAddress1 = '0;
`endif

  assign in_ready       = in_ready_q;
  assign Y_WE           = we_q;
  assign Y_WriteAddress = wr_addr_q;
  assign Y_WriteBus     = wr_bus_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_y_row_loader.sv
// tb/tb_y_row_loader.sv - directed table-driven bench for y_row_loader
module tb_y_row_loader;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [10:0]  base_addr = '0;
  logic [11:0]  num_rows = '0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_ready;
  logic         Y_WE;
  logic [10:0]  Y_WriteAddress;
  logic [255:0] Y_WriteBus;
  logic [10:0]  Y_ReadAddress1;
  logic [255:0] Y_ReadBus1 = '0;
  logic         busy;
  logic         done;
  logic         error;

  int checks = 0;
  int failures = 0;

`ifdef READBACK_CHECK_EN
  localparam int ROW_CYC = 11;
`else
  localparam int ROW_CYC = 9;
`endif

  y_row_loader dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .num_rows       (num_rows),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .Y_WE           (Y_WE),
    .Y_WriteAddress (Y_WriteAddress),
    .Y_WriteBus     (Y_WriteBus),
    .Y_ReadAddress1 (Y_ReadAddress1),
    .Y_ReadBus1     (Y_ReadBus1),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clock = ~clock;

  // SRAM model: synchronous write, synchronous read with 1-cycle latency,
  // optional bit-0 corruption on one address.
  logic [255:0] mem [0:2047];
  logic         corrupt_en = 1'b0;
  logic [10:0]  corrupt_addr = '0;

  always @(posedge clock) begin
    if (Y_WE) mem[Y_WriteAddress] <= Y_WriteBus;
    Y_ReadBus1 <= mem[Y_ReadAddress1] ^ {255'b0, (corrupt_en && (Y_ReadAddress1 == corrupt_addr))};
  end

  // Monitor on the falling edge, away from the active edge.
  int cyc = 0, we_cnt = 0, done_cnt = 0, rdy_cnt = 0, busy_cnt = 0;
  int start_cyc = 0, done_cyc = 0;
  logic [10:0]  wa [0:255];
  logic [255:0] wb [0:255];

  always @(negedge clock) begin
    if (start && !busy) start_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (Y_WE) begin
      wa[we_cnt[7:0]] = Y_WriteAddress;
      wb[we_cnt[7:0]] = Y_WriteBus;
      we_cnt++;
    end
    if (in_ready) rdy_cnt++;
    if (busy) busy_cnt++;
    cyc++;
  end

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [10:0]  base;
    logic [11:0]  nrows;
    bit           toggle;
    int           restart;    // feed iteration at which a spurious start is pulsed, -1 none
    logic [31:0]  word0;
    logic [255:0] row0;       // hand-computed first row
    logic [10:0]  last_addr;  // hand-computed last written address
    int           lat;        // start-to-done cycles, -1 skip
    int           rdy;        // in_ready high cycles, -1 skip
    int           bsy;        // busy high cycles, -1 skip
    bit           err;
  } vec_t;

  task automatic run_vector(input int id, input vec_t v);
    int we0, dn0, rdy0, bsy0, sent, it, total, n, idx;
    bit want;
    logic [255:0] row;
    logic [10:0] a;
    we0 = we_cnt; dn0 = done_cnt; rdy0 = rdy_cnt; bsy0 = busy_cnt;
    total = 8 * int'(v.nrows);
    @(posedge clock); #1;
    start = 1'b1; base_addr = v.base; num_rows = v.nrows;
    @(posedge clock); #1;
    start = 1'b0;
    sent = 0; it = 0;
    while (sent < total && it < 400) begin
      want = v.toggle ? ((it % 2) == 0) : 1'b1;
      in_valid = want;
      in_data = v.word0 + 32'(sent);
      if (want && in_ready) sent++;
      if (it == v.restart) begin
        start = 1'b1; base_addr = 11'h123; num_rows = 12'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      it++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk_int($sformatf("v%0d_words_fed", id), sent, total);
    it = 0;
    while (done_cnt == dn0 && it < 60) begin
      @(posedge clock); #1;
      it++;
    end
    repeat (4) @(posedge clock);
    #1;
    n = we_cnt - we0;
    chk_int($sformatf("v%0d_write_cycles", id), n, int'(v.nrows));
    chk_int($sformatf("v%0d_done_pulses", id), done_cnt - dn0, 1);
    for (int i = 0; i < n && i < int'(v.nrows); i++) begin
      for (int k = 0; k < 8; k++) row[32*k +: 32] = v.word0 + 32'(8*i + k);
      a = v.base + 11'(i);
      idx = (we0 + i) % 256;
      chk_int($sformatf("v%0d_addr%0d", id, i), int'(wa[idx]), int'(a));
      chk_vec($sformatf("v%0d_row%0d", id, i), wb[idx], row);
    end
    if (n > 0) begin
      chk_vec($sformatf("v%0d_row0_hand", id), wb[we0 % 256], v.row0);
      chk_int($sformatf("v%0d_last_addr", id), int'(wa[(we0 + n - 1) % 256]), int'(v.last_addr));
    end
    if (v.lat >= 0) chk_int($sformatf("v%0d_latency", id), done_cyc - start_cyc, v.lat);
    if (v.rdy >= 0) chk_int($sformatf("v%0d_ready_cycles", id), rdy_cnt - rdy0, v.rdy);
    if (v.bsy >= 0) chk_int($sformatf("v%0d_busy_cycles", id), busy_cnt - bsy0, v.bsy);
    chk_int($sformatf("v%0d_busy_end", id), int'(busy), 0);
    chk_int($sformatf("v%0d_done_end", id), int'(done), 0);
    chk_int($sformatf("v%0d_error", id), int'(error), int'(v.err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_int({tag, "_in_ready"}, int'(in_ready), 0);
    chk_int({tag, "_we"}, int'(Y_WE), 0);
    chk_int({tag, "_busy"}, int'(busy), 0);
    chk_int({tag, "_done"}, int'(done), 0);
    chk_int({tag, "_error"}, int'(error), 0);
    chk_int({tag, "_waddr"}, int'(Y_WriteAddress), 0);
    chk_vec({tag, "_wbus"}, Y_WriteBus, 256'h0);
    chk_int({tag, "_raddr"}, int'(Y_ReadAddress1), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs [5];

  initial begin
    int we0, dn0;
    vec_t rb;

    vecs[0] = '{base: 11'h010, nrows: 12'd2, toggle: 1'b0, restart: -1, word0: 32'h0,
                row0: 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000,
                last_addr: 11'h011, lat: 2*ROW_CYC + 1, rdy: 16, bsy: 2*ROW_CYC, err: 1'b0};
    vecs[1] = '{base: 11'h7FF, nrows: 12'd2, toggle: 1'b0, restart: -1, word0: 32'h100,
                row0: 256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100,
                last_addr: 11'h000, lat: 2*ROW_CYC + 1, rdy: 16, bsy: 2*ROW_CYC, err: 1'b0};
    vecs[2] = '{base: 11'h155, nrows: 12'd0, toggle: 1'b0, restart: -1, word0: 32'h0,
                row0: 256'h0, last_addr: 11'h000, lat: 1, rdy: 0, bsy: 0, err: 1'b0};
    vecs[3] = '{base: 11'h200, nrows: 12'd1, toggle: 1'b1, restart: 4, word0: 32'hA5A50000,
                row0: 256'hA5A50007_A5A50006_A5A50005_A5A50004_A5A50003_A5A50002_A5A50001_A5A50000,
                last_addr: 11'h200, lat: -1, rdy: -1, bsy: -1, err: 1'b0};
    vecs[4] = '{base: 11'h400, nrows: 12'd3, toggle: 1'b0, restart: -1, word0: 32'hDEAD0000,
                row0: 256'hDEAD0007_DEAD0006_DEAD0005_DEAD0004_DEAD0003_DEAD0002_DEAD0001_DEAD0000,
                last_addr: 11'h402, lat: 3*ROW_CYC + 1, rdy: 24, bsy: 3*ROW_CYC, err: 1'b0};

    // Reset state, during and after reset.
    #2;
    chk_reset_outputs("rst_hold");
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk_reset_outputs("rst_release");

    for (int v = 0; v < 5; v++) run_vector(v, vecs[v]);

    // Reset in the middle of a load: 5 words in, then abort.
    we0 = we_cnt; dn0 = done_cnt;
    @(posedge clock); #1;
    start = 1'b1; base_addr = 11'h300; num_rows = 12'd2;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 32'hBAD00000 + 32'(i);
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #2;
    chk_reset_outputs("abort");
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    chk_int("abort_no_write", we_cnt - we0, 0);
    chk_int("abort_no_done", done_cnt - dn0, 0);
    run_vector(10, vecs[0]);

`ifdef READBACK_CHECK_EN
    rb = '{base: 11'h020, nrows: 12'd3, toggle: 1'b0, restart: -1, word0: 32'h55550000,
           row0: 256'h55550007_55550006_55550005_55550004_55550003_55550002_55550001_55550000,
           last_addr: 11'h022, lat: 3*ROW_CYC + 1, rdy: 24, bsy: 3*ROW_CYC, err: 1'b1};
    corrupt_addr = 11'h021;
    corrupt_en = 1'b1;
    run_vector(20, rb);
    corrupt_en = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk_int("rb_error_sticky", int'(error), 1);
    run_vector(21, vecs[0]);
`else
    rb = vecs[0];
    chk_int("no_rb_raddr", int'(Y_ReadAddress1), 0);
    chk_int("no_rb_error", int'(error), int'(rb.err));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
